router_fifo: RTL and testbench

Per-destination output buffer of the 1x3 router. It sits directly downstream of the register stage and captures that stage's byte stream (header, payload, parity) on every write strobe. Each entry carries a header-marker bit. On the read side it tracks packet length, so the output port knows where each packet ends. The router instantiates three copies, one per output channel.

---
 rtl/router_fifo_pkg.sv | 26 ++
 rtl/router_fifo_mem.sv | 24 ++
 rtl/router_fifo.sv | 115 +++++++++++
 tb/tb_router_fifo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/router_fifo_pkg.sv
// Shared router definitions: byte width and header field layout.
// Helper turns a header byte into its remaining-bytes count.
package router_fifo_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int LEN_MSB     = 7;
  localparam int LEN_LSB     = 2;
  localparam int DEST_MSB    = 1;
  localparam int DEST_LSB    = 0;
  localparam int MAX_PAYLOAD = 63;
  localparam int CNT_W       = 7;

  typedef enum logic [1:0] {
    DEST_0 = 2'd0,
    DEST_1 = 2'd1,
    DEST_2 = 2'd2
  } dest_e;

  // payload length plus the trailing parity byte
  function automatic logic [CNT_W-1:0] hdr_cnt(
    input logic [LEN_MSB:0] hdr
  );
    return {1'b0, hdr[LEN_MSB:LEN_LSB]} + CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Entry storage for one output channel.
// Synchronous write, asynchronous read.
module router_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [WIDTH:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [WIDTH:0] rdata
);

  logic [WIDTH:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router.
// Tracks packet length on the read side to flag the parity byte.
module router_fifo
  import router_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             pkt_end
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             pkt_end_q, pkt_end_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH:0]   rd_data;

  router_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clock (clock),
    .we    (wr_acc && !soft_reset),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({lfd_state, data_in}),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

  // flags are registered, so a write while full is refused even
  // when a read frees an entry in the same cycle
  always_comb begin
    wr_acc = write_enb && !full_q;
    rd_acc = read_enb && !empty_q;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pkt_cnt_d    = pkt_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    pkt_end_d    = 1'b0;
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pkt_cnt_d  = '0;
      data_out_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) begin
        rd_ptr_d     = rd_ptr_q + PW'(1);
        data_out_d   = rd_data[WIDTH-1:0];
        data_valid_d = 1'b1;
        if (rd_data[WIDTH]) begin
          pkt_cnt_d = hdr_cnt(rd_data[LEN_MSB:0]);
        end else if (pkt_cnt_q != '0) begin
          pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
          pkt_end_d = (pkt_cnt_q == CNT_W'(1));
        end
      end
    end
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
              (wr_ptr_d[AW] != rd_ptr_d[AW]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      pkt_end_q    <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      pkt_end_q    <= pkt_end_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign pkt_end    = pkt_end_q;

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: directed packets, full/wrap,
// simultaneous access at full, soft flush, back-to-back packets.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       full;
  logic       empty;
  logic [7:0] data_out;
  logic       data_valid;
  logic       pkt_end;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] sb[$];
  logic [8:0] exp_q;

  always #5 clock = ~clock;

  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .full       (full),
    .empty      (empty),
    .data_out   (data_out),
    .data_valid (data_valid),
    .pkt_end    (pkt_end)
  );

  // monitor: pops one expectation per data_valid pulse
  always @(posedge clock) begin
    #1;
    if (pkt_end && !data_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pkt_end_pulse: pkt_end=1 without data_valid");
    end
    if (data_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: got data %h end %b, none expected",
                 data_out, pkt_end);
      end else begin
        exp_q = sb.pop_front();
        if ({pkt_end, data_out} !== exp_q) begin
          n_bad++;
          $display("FAIL rd_data: got data %h end %b, want data %h end %b",
                   data_out, pkt_end, exp_q[7:0], exp_q[8]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // drive one clock of strobes from a falling edge
  task automatic cyc(input logic we, input logic re,
                     input logic [7:0] d, input logic lfd);
    write_enb = we;
    read_enb  = re;
    data_in   = d;
    lfd_state = lfd;
    @(negedge clock);
    write_enb = 1'b0;
    read_enb  = 1'b0;
    lfd_state = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d, input logic lfd);
    cyc(1'b1, 1'b0, d, lfd);
  endtask

  task automatic rd(input logic [7:0] d, input logic pe);
    sb.push_back({pe, d});
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d reads outstanding, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset      = 1'b1;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_empty", {7'd0, empty}, 8'h01);
    chk("rst_full", {7'd0, full}, 8'h00);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_valid", {7'd0, data_valid}, 8'h00);

    // packet of length 3
    wr(8'h0D, 1'b1);
    chk("pkt1_not_empty", {7'd0, empty}, 8'h00);
    wr(8'hA1, 1'b0);
    wr(8'hA2, 1'b0);
    wr(8'hA3, 1'b0);
    wr(8'h0C, 1'b0);
    rd(8'h0D, 1'b0);
    rd(8'hA1, 1'b0);
    rd(8'hA2, 1'b0);
    rd(8'hA3, 1'b0);
    rd(8'h0C, 1'b1);
    drain("pkt1_drain");
    chk("pkt1_empty", {7'd0, empty}, 8'h01);
    chk("pkt1_hold", data_out, 8'h0C);

    // fill across the wrap point, overflow is dropped
    for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i), 1'b0);
    chk("fill_full", {7'd0, full}, 8'h01);
    wr(8'hFF, 1'b0);
    chk("ovf_full", {7'd0, full}, 8'h01);
    sb.push_back({1'b0, 8'h10});
    cyc(1'b1, 1'b1, 8'hEE, 1'b0);
    chk("rw_full_drop", {7'd0, full}, 8'h00);
    for (int i = 1; i < 16; i++) rd(8'h10 + 8'(i), 1'b0);
    chk("wrap_empty", {7'd0, empty}, 8'h01);
    drain("wrap_drain");

    // flush mid-packet
    wr(8'h0D, 1'b1);
    wr(8'hC1, 1'b0);
    wr(8'hC2, 1'b0);
    wr(8'hC3, 1'b0);
    wr(8'h55, 1'b0);
    rd(8'h0D, 1'b0);
    rd(8'hC1, 1'b0);
    rd(8'hC2, 1'b0);
    drain("pre_soft_drain");
    soft_reset = 1'b1;
    @(negedge clock);
    soft_reset = 1'b0;
    chk("soft_empty", {7'd0, empty}, 8'h01);
    chk("soft_data_out", data_out, 8'h00);
    chk("soft_valid", {7'd0, data_valid}, 8'h00);
    wr(8'h05, 1'b1);
    wr(8'hD1, 1'b0);
    wr(8'h77, 1'b0);
    rd(8'h05, 1'b0);
    rd(8'hD1, 1'b0);
    rd(8'h77, 1'b1);
    drain("post_soft_drain");

    // back-to-back packets of length 1 and 2
    wr(8'h05, 1'b1);
    wr(8'hE1, 1'b0);
    wr(8'h31, 1'b0);
    wr(8'h09, 1'b1);
    wr(8'hF1, 1'b0);
    wr(8'hF2, 1'b0);
    wr(8'h32, 1'b0);
    rd(8'h05, 1'b0);
    rd(8'hE1, 1'b0);
    rd(8'h31, 1'b1);
    rd(8'h09, 1'b0);
    rd(8'hF1, 1'b0);
    rd(8'hF2, 1'b0);
    rd(8'h32, 1'b1);
    drain("b2b_drain");
    chk("b2b_empty", {7'd0, empty}, 8'h01);

    // orphan read after a closed packet must not flag pkt_end
    wr(8'h44, 1'b0);
    rd(8'h44, 1'b0);
    drain("orphan_drain");

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
